// File: rtl/vector_regfile_masked_if.sv
// Bus bundle for vector_regfile_masked: read/write ports, clear request and status.
// master drives addresses/data/requests; slave (the register file) returns read data and status.
interface vector_regfile_masked_if #(
    parameter int LANES  = 16,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 4
);
    logic                           we3;
    logic [ADDR_W-1:0]              ra1;
    logic [ADDR_W-1:0]              ra2;
    logic [ADDR_W-1:0]              ra3;
    logic [LANES*LANE_W-1:0]        wd3;
    logic [LANES-1:0]               wmask;
    logic                           clr_req;
    logic [LANES-1:0][LANE_W-1:0]   rd1;
    logic [LANES-1:0][LANE_W-1:0]   rd2;
    logic                           clr_busy;
    logic                           wr_drop;

    modport master (
        output we3, ra1, ra2, ra3, wd3, wmask, clr_req,
        input  rd1, rd2, clr_busy, wr_drop
    );

    modport slave (
        input  we3, ra1, ra2, ra3, wd3, wmask, clr_req,
        output rd1, rd2, clr_busy, wr_drop
    );
endinterface

// File: rtl/vector_regfile_masked.sv
// Vector register file: 2 read / 1 masked write port with a sequenced clear sweep.
// Optional write-through bypass on both read ports when VREGFILE_BYPASS_EN is defined.
//
// state | meaning
// IDLE  | normal operation, masked writes accepted, clr_req starts a sweep
// CLEAR | zeroing one register per cycle at clr_idx; writes dropped, reads forced to 0
module vector_regfile_masked #(
    parameter int NUM_REGS = 16,
    parameter int LANES    = 16,
    parameter int LANE_W   = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vector_regfile_masked_if.slave  bus
);

    if (ADDR_W != $clog2(NUM_REGS)) begin : g_bad_addr_w
        $error("vector_regfile_masked: ADDR_W must equal clog2(NUM_REGS)");
    end
    if (NUM_REGS < 2) begin : g_bad_num_regs
        $error("vector_regfile_masked: NUM_REGS must be at least 2");
    end

    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_idx;
    logic              clr_busy_q;
    logic              wr_drop_q;
    vec_t              mem [NUM_REGS];
    vec_t              wd_vec;
    logic              wr_any;
    vec_t              rd1_v;
    vec_t              rd2_v;

    // Lane i of the flat write bus lines up with lane i of the packed vector.
    assign wd_vec = vec_t'(bus.wd3);
    assign wr_any = bus.we3 && (bus.wmask != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            clr_busy_q <= 1'b1;
            wr_drop_q  <= 1'b0;
        end else begin
            wr_drop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state      <= CLEAR;
                        clr_idx    <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_req is deliberately ignored here so a sweep never restarts.
                    wr_drop_q <= wr_any;
                    clr_idx   <= clr_idx + ADDR_W'(1);
                    if (clr_idx == LAST_IDX) begin
                        state      <= IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= CLEAR;
                    clr_idx    <= '0;
                    clr_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the sweep is the only clearing mechanism.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (bus.we3) begin
                for (int i = 0; i < LANES; i++) begin
                    if (bus.wmask[i]) begin
                        mem[bus.ra3][i] <= wd_vec[i];
                    end
                end
            end
        end
    end

    always_comb begin
        rd1_v = mem[bus.ra1];
        rd2_v = mem[bus.ra2];
`ifdef VREGFILE_BYPASS_EN
        if (bus.we3 && (state == IDLE)) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wmask[i] && (bus.ra1 == bus.ra3)) begin
                    rd1_v[i] = wd_vec[i];
                end
                if (bus.wmask[i] && (bus.ra2 == bus.ra3)) begin
                    rd2_v[i] = wd_vec[i];
                end
            end
        end
`else
        // New data becomes visible the cycle after the write edge.
`endif
        if (clr_busy_q) begin
            rd1_v = '0;
            rd2_v = '0;
        end
    end

    assign bus.rd1      = rd1_v;
    assign bus.rd2      = rd2_v;
    assign bus.clr_busy = clr_busy_q;
    assign bus.wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_vector_regfile_masked.sv
// Scoreboard bench for vector_regfile_masked: stimulus queues expectations, a negedge monitor checks them.
module tb_vector_regfile_masked;

    localparam int NR = 16;
    localparam int LN = 16;
    localparam int LW = 8;
    localparam int AW = 4;
    localparam int W  = LN * LW;

    localparam int SEL_RD1  = 0;
    localparam int SEL_RD2  = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_DROP = 3;

    localparam logic [W-1:0] V0   = {16{8'hA5}};
    localparam logic [W-1:0] V1   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [W-1:0] V2   = 128'hFEDCBA9876543210FEDCBA9876543210;
    localparam logic [W-1:0] V3A  = {16{8'h11}};
    localparam logic [W-1:0] V3M  = 128'h11111111_11111111_FFFFFFFF_11111111;
    localparam logic [W-1:0] VAB  = {16{8'hAB}};
    localparam logic [W-1:0] VAB0 = {{(W-8){1'b0}}, 8'hAB};
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_regfile_masked_if #(.LANES(LN), .LANE_W(LW), .ADDR_W(AW)) bus ();

    vector_regfile_masked #(
        .NUM_REGS(NR), .LANES(LN), .LANE_W(LW), .ADDR_W(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        int           sel;
        logic [W-1:0] val;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [W-1:0] mon_act;
    int           total = 0;
    int           bad   = 0;

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            case (mon_e.sel)
                SEL_RD1:  mon_act = bus.rd1;
                SEL_RD2:  mon_act = bus.rd2;
                SEL_BUSY: mon_act = {{(W-1){1'b0}}, bus.clr_busy};
                default:  mon_act = {{(W-1){1'b0}}, bus.wr_drop};
            endcase
            total++;
            if (mon_act !== mon_e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", mon_e.name, mon_act, mon_e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input string n, input int sel, input logic [W-1:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [LN-1:0] m);
        bus.we3   = 1'b1;
        bus.ra3   = a;
        bus.wd3   = d;
        bus.wmask = m;
        tick();
        bus.we3   = 1'b0;
        bus.wmask = '0;
    endtask

    task automatic read_pair(input string n, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                             input logic [W-1:0] e1, input logic [W-1:0] e2);
        bus.ra1 = a1;
        bus.ra2 = a2;
        expect_sig({n, "_rd1"}, SEL_RD1, e1);
        expect_sig({n, "_rd2"}, SEL_RD2, e2);
        tick();
    endtask

    task automatic check_all_zero(input string n);
        for (int r = 0; r < NR; r++) begin
            read_pair(n, AW'(r), AW'(NR - 1 - r), ZERO, ZERO);
        end
    endtask

    // Busy must read 1 in the release cycle and the next len-1 cycles, then 0.
    task automatic busy_run(input string n, input int len);
        for (int k = 0; k <= len; k++) begin
            expect_sig(n, SEL_BUSY, (k < len) ? ONE : ZERO);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.we3     = 1'b0;
        bus.ra1     = '0;
        bus.ra2     = '0;
        bus.ra3     = '0;
        bus.wd3     = '0;
        bus.wmask   = '0;
        bus.clr_req = 1'b0;

        // Reset sweep
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        expect_sig("rst_wr_drop", SEL_DROP, ZERO);
        busy_run("rst_busy", NR);
        check_all_zero("rst_zero");

        // Full writes and dual reads
        write_reg(4'd0, V0, 16'hFFFF);
        write_reg(4'd1, V1, 16'hFFFF);
        write_reg(4'd2, V2, 16'hFFFF);
        read_pair("rd_1_2", 4'd1, 4'd2, V1, V2);
        read_pair("rd_2_0", 4'd2, 4'd0, V2, V0);
        read_pair("rd_1_1", 4'd1, 4'd1, V1, V1);

        // Masked writes
        write_reg(4'd3, V3A, 16'hFFFF);
        write_reg(4'd3, {W{1'b1}}, 16'h00F0);
        read_pair("mask_f0", 4'd3, 4'd0, V3M, V0);
        write_reg(4'd3, ZERO, 16'h0000);
        read_pair("mask_none", 4'd3, 4'd3, V3M, V3M);
        expect_sig("mask_no_drop", SEL_DROP, ZERO);
        tick();

        // Bypass / write-cycle visibility
        bus.ra1   = 4'd4;
        bus.ra2   = 4'd4;
        bus.we3   = 1'b1;
        bus.ra3   = 4'd4;
        bus.wd3   = VAB;
        bus.wmask = 16'h0001;
`ifdef VREGFILE_BYPASS_EN
        expect_sig("byp_same_rd1", SEL_RD1, VAB0);
        expect_sig("byp_same_rd2", SEL_RD2, VAB0);
`else
        expect_sig("byp_same_rd1", SEL_RD1, ZERO);
        expect_sig("byp_same_rd2", SEL_RD2, ZERO);
`endif
        tick();
        bus.we3   = 1'b0;
        bus.wmask = '0;
        expect_sig("byp_next_rd1", SEL_RD1, VAB0);
        expect_sig("byp_next_rd2", SEL_RD2, VAB0);
        tick();

        // Clear request colliding with writes and a second request
        bus.clr_req = 1'b1;
        bus.we3     = 1'b1;
        bus.ra3     = 4'd5;
        bus.wd3     = {16{8'h55}};
        bus.wmask   = 16'hFFFF;
        expect_sig("clr_accept_busy", SEL_BUSY, ZERO);
        tick();
        bus.clr_req = 1'b0;
        bus.we3     = 1'b0;
        bus.wmask   = '0;
        for (int k = 1; k <= NR + 1; k++) begin
            case (k)
                3: begin
                    bus.we3   = 1'b1;
                    bus.ra3   = 4'd6;
                    bus.wd3   = {16{8'h66}};
                    bus.wmask = 16'hFFFF;
                end
                4: begin
                    bus.we3     = 1'b0;
                    bus.wmask   = '0;
                    bus.clr_req = 1'b1;
                end
                5: bus.clr_req = 1'b0;
                6: begin
                    bus.we3   = 1'b1;
                    bus.ra3   = 4'd6;
                    bus.wmask = 16'h0000;
                end
                7: bus.we3 = 1'b0;
                default: ;
            endcase
            expect_sig("clr_busy", SEL_BUSY, (k <= NR) ? ONE : ZERO);
            expect_sig((k == 4) ? "clr_drop_pulse" : "clr_drop_quiet", SEL_DROP,
                       (k == 4) ? ONE : ZERO);
            tick();
        end
        check_all_zero("clr_zero");

        // Reset in the middle of a sweep, with a write pending
        write_reg(4'd7, {16{8'h77}}, 16'hFFFF);
        read_pair("pre_rst_r7", 4'd7, 4'd7, {16{8'h77}}, {16{8'h77}});
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            expect_sig("mid_busy", SEL_BUSY, ONE);
            tick();
        end
        rst_n     = 1'b0;
        bus.we3   = 1'b1;
        bus.ra3   = 4'd7;
        bus.wd3   = {16{8'h99}};
        bus.wmask = 16'hFFFF;
        expect_sig("mid_rst_busy", SEL_BUSY, ONE);
        tick();
        rst_n     = 1'b1;
        bus.we3   = 1'b0;
        bus.wmask = '0;
        expect_sig("rst_no_drop", SEL_DROP, ZERO);
        busy_run("mid_rst_run", NR);
        check_all_zero("mid_rst_zero");

        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
